ex_stage_pipe: RTL and testbench
================================

// Module: ex_stage_pipe
// PURPOSE
//  Registered, parametrised execute stage between ID/EX and MEM.
//  - Single-cycle ALU ops.
//  - Iterative multiply/divide unit (MDU) with architectural HI/LO.
//  - Valid/ready handshake on both sides; flush input.
//  - Opaque control sideband carried through to MEM/WB aligned with the result.
// PARAMETERS
//  XLEN       32  datapath width (even, >=8)
//  RADDR_W    5   register-number width; RA destination = all ones
//  ALU_OP_W   5   ALU opcode width (shared ALU encoding)
//  CTRL_W     16  width of opaque MEM/WB control sideband
//  MUL_STEP   1   multiplier bits retired per cycle; must divide XLEN
// PORTS
//  clk        in   1         clock, rising edge
//  rst_b      in   1         async active-low reset
//  flush      in   1         kill stage contents (branch/exception)
//  in_valid   in   1         ID/EX bundle valid
//  in_ready   out  1         stage accepts bundle this cycle
//  rs_data    in   XLEN      operand A
//  rt_data    in   XLEN      operand B / store data
//  imm_ext    in   XLEN      extended immediate
//  shamt      in   5         shift amount
//  inst_rt    in   RADDR_W   rt field
//  inst_rd    in   RADDR_W   rd field
//  dest_sel   in   2         00 rt, 01 rd, 10 RA(all ones), 11 rt
//  alu_src    in   1         1: B=imm_ext, 0: B=rt_data
//  alu_op     in   ALU_OP_W  ALU operation
//  mdu_op     in   3         0 none,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MFHI,6 MFLO
//  ctrl_in    in   CTRL_W    sideband (reg_we, mem ctrl, halt, ...)
//  out_valid  out  1         EX/MEM bundle valid
//  out_ready  in   1         MEM accepts bundle
//  alu_result out  XLEN      ALU/MFHI/MFLO result
//  zero       out  1         alu_result==0
//  rt_out     out  XLEN      registered rt_data
//  rd_num     out  RADDR_W   selected destination
//  ctrl_out   out  CTRL_W    registered sideband
//  mdu_busy   out  1         MDU iterating
// BEHAVIOUR
//  Reset: every output register, HI, LO and FSM = 0/IDLE.
//    out_valid=0, mdu_busy=0, in_ready=1.
//  in_ready = state==IDLE && (!out_valid || out_ready).
//    Accept = in_valid && in_ready.
//  Output register:
//    - Loads on accept for non-MDU ops and MFHI/MFLO: latency 1 cycle.
//    - Holds stable while out_valid && !out_ready.
//    - Clears out_valid on a non-accepting cycle when out_ready=1.
//  MFHI/MFLO read the committed HI/LO.
//  FSM IDLE->MUL|DIV on accept of mdu_op 1..4; operands are latched.
//  MUL: XLEN/MUL_STEP cycles, shift-add on magnitudes.
//  DIV: XLEN cycles, restoring radix-2 on magnitudes.
//  Signed ops: operands abs'd, then signs fixed.
//    - Product sign = sA^sB.
//    - Quotient sign = sA^sB; remainder sign = sA.
//  Divide by zero: LO=all ones, HI=dividend; same cycle count.
//  MDU ops complete via MUL|DIV->DONE->IDLE.
//    - DONE writes HI/LO (product: HI=upper, LO=lower; div: LO=quot, HI=rem).
//    - DONE emits out_valid with alu_result=0 and the captured ctrl/rd_num.
//    - DONE waits while out_valid && !out_ready.
//  mdu_busy=1 in MUL, DIV, DONE.
//  flush (priority over all):
//    - next cycle out_valid=0, FSM->IDLE.
//    - In-flight MDU aborted; HI/LO unchanged.
//    - Same-cycle in_valid is dropped.
//  zero is computed from the registered alu_result.
//  Shifts use shamt.
//  Operand B is muxed combinationally from inputs; no sensitivity-list latching.
//  rt_out/ctrl_out/rd_num are captured only on accept, never passed through.
// STRUCTURE
//  Package ex_pkg:
//    - mdu_op_e, ex_state_e {IDLE,MUL,DIV,DONE}
//    - DEST_RT/RD/RA constants, ALU opcode constants
//  Sub-module ex_mdu: iterative mul/div with start/done/abort and HI/LO outputs.
//  Top: instantiates the existing ALU, ex_mdu, and the pipeline register.
// TESTING
//  1. ADD: rs=5, rt=7, alu_src=0, dest_sel=01, rd=9
//     -> next cycle out_valid=1, alu_result=12, rd_num=9, zero=0.
//  2. Backpressure: out_ready=0 for 3 cycles after a valid
//     -> outputs stable, in_ready=0; release -> accept resumes.
//  3. MULT -3*4 with MUL_STEP=1 -> mdu_busy 33 cycles, HI=FFFFFFFF, LO=FFFFFFF4.
//     Then MFLO -> alu_result=FFFFFFF4.
//  4. DIV -7/2 -> LO=FFFFFFFD, HI=FFFFFFFF.
//     DIVU 7/0 -> LO=FFFFFFFF, HI=7.
//  5. Flush at MUL cycle 10 (HI/LO previously 1/2) -> FSM IDLE next cycle.
//     out_valid=0; MFHI then returns 1.
//  6. rst_b low mid-DIV -> outputs 0 immediately; after release in_ready=1.
//     Also: dest_sel=10 -> rd_num=1F.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared types and constants for the execute stage: MDU opcodes, FSM states,
// destination selectors and the ALU opcode map.
package ex_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MFHI  = 3'd5,
        MDU_MFLO  = 3'd6
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } ex_state_e;

    localparam logic [1:0] DEST_RT = 2'b00;
    localparam logic [1:0] DEST_RD = 2'b01;
    localparam logic [1:0] DEST_RA = 2'b10;

    // Shift ops take their amount from shamt and shift operand B.
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_NOR  = 5'd5;
    localparam logic [4:0] ALU_SLT  = 5'd6;
    localparam logic [4:0] ALU_SLTU = 5'd7;
    localparam logic [4:0] ALU_SLL  = 5'd8;
    localparam logic [4:0] ALU_SRL  = 5'd9;
    localparam logic [4:0] ALU_SRA  = 5'd10;
    localparam logic [4:0] ALU_LUI  = 5'd11;

endpackage

// File: rtl/ex_mdu.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, sign fix-up at DONE, architectural HI/LO committed on exit.
module ex_mdu
    import ex_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            abort,
    input  logic            done_ack,
    output logic [1:0]      state,
    output logic            busy,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int MUL_CYC = XLEN / MUL_STEP;
    localparam int CNT_W   = $clog2(XLEN + 1);

    ex_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*XLEN-1:0] acc_q, mcand_q, step_sum, prod;
    logic [XLEN-1:0]   mplier_q, rem_q, quot_q, dvsr_q, dividend_q;
    logic [XLEN-1:0]   mag_a, mag_b, rem_nxt, quot_nxt, hi_d, lo_d;
    logic [XLEN:0]     rem_sh, trial;
    logic              is_mul_q, neg_q, neg_r_q, dbz_q;
    logic              sgn_op, sa, sb, commit;

    assign state = state_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start) state_d = (op == MDU_MULT || op == MDU_MULTU) ? MUL : DIV;
                MUL:  if (cnt_q == CNT_W'(MUL_CYC - 1)) state_d = DONE;
                DIV:  if (cnt_q == CNT_W'(XLEN - 1)) state_d = DONE;
                DONE: if (done_ack) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy   = (state_q != IDLE);
        commit = (state_q == DONE) && done_ack && !abort;
    end

    always_comb begin
        sgn_op = (op == MDU_MULT) || (op == MDU_DIV);
        sa     = sgn_op & a[XLEN-1];
        sb     = sgn_op & b[XLEN-1];
        mag_a  = sa ? -a : a;
        mag_b  = sb ? -b : b;
    end

    // One multiply step retires MUL_STEP multiplier bits.
    always_comb begin
        step_sum = '0;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (mplier_q[j]) step_sum = step_sum + (mcand_q << j);
        end
    end

    always_comb begin
        rem_sh = {rem_q, quot_q[XLEN-1]};
        trial  = rem_sh - {1'b0, dvsr_q};
        if (!trial[XLEN]) begin
            rem_nxt  = trial[XLEN-1:0];
            quot_nxt = {quot_q[XLEN-2:0], 1'b1};
        end else begin
            rem_nxt  = rem_sh[XLEN-1:0];
            quot_nxt = {quot_q[XLEN-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            dvsr_q     <= '0;
            dividend_q <= '0;
            is_mul_q   <= 1'b0;
            neg_q      <= 1'b0;
            neg_r_q    <= 1'b0;
            dbz_q      <= 1'b0;
        end else if (state_q == IDLE) begin
            if (start && !abort) begin
                is_mul_q   <= (op == MDU_MULT) || (op == MDU_MULTU);
                neg_q      <= sa ^ sb;
                neg_r_q    <= sa;
                dbz_q      <= (b == '0);
                dividend_q <= a;
                acc_q      <= '0;
                mcand_q    <= {{XLEN{1'b0}}, mag_a};
                mplier_q   <= mag_b;
                rem_q      <= '0;
                quot_q     <= mag_a;
                dvsr_q     <= mag_b;
                cnt_q      <= '0;
            end
        end else if (state_q == MUL) begin
            acc_q    <= acc_q + step_sum;
            mcand_q  <= mcand_q << MUL_STEP;
            mplier_q <= mplier_q >> MUL_STEP;
            cnt_q    <= cnt_q + 1'b1;
        end else if (state_q == DIV) begin
            rem_q  <= rem_nxt;
            quot_q <= quot_nxt;
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    // Divide by zero keeps the iteration count but reports LO=all ones, HI=dividend.
    always_comb begin
        prod = neg_q ? -acc_q : acc_q;
        if (is_mul_q) begin
            hi_d = prod[2*XLEN-1:XLEN];
            lo_d = prod[XLEN-1:0];
        end else if (dbz_q) begin
            hi_d = dividend_q;
            lo_d = '1;
        end else begin
            hi_d = neg_r_q ? -rem_q : rem_q;
            lo_d = neg_q ? -quot_q : quot_q;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            hi <= '0;
            lo <= '0;
        end else if (commit) begin
            hi <= hi_d;
            lo <= lo_d;
        end
    end

endmodule

// File: rtl/ex_stage_pipe.sv
// Execute stage: single-cycle ALU, iterative MDU with HI/LO, and the EX/MEM
// output register carrying the control sideband aligned with the result.
module ex_stage_pipe
    import ex_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int RADDR_W  = 5,
    parameter int ALU_OP_W = 5,
    parameter int CTRL_W   = 16,
    parameter int MUL_STEP = 1
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     rs_data,
    input  logic [XLEN-1:0]     rt_data,
    input  logic [XLEN-1:0]     imm_ext,
    input  logic [4:0]          shamt,
    input  logic [RADDR_W-1:0]  inst_rt,
    input  logic [RADDR_W-1:0]  inst_rd,
    input  logic [1:0]          dest_sel,
    input  logic                alu_src,
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic [2:0]          mdu_op,
    input  logic [CTRL_W-1:0]   ctrl_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     alu_result,
    output logic                zero,
    output logic [XLEN-1:0]     rt_out,
    output logic [RADDR_W-1:0]  rd_num,
    output logic [CTRL_W-1:0]   ctrl_out,
    output logic                mdu_busy
);

    logic [1:0]         mdu_state;
    logic [XLEN-1:0]    hi, lo, op_b, alu_y, ex_y, cap_rt;
    logic [RADDR_W-1:0] dest, cap_rd;
    logic [CTRL_W-1:0]  cap_ctrl;
    logic [4:0]         op5;
    logic               out_free, accept, mdu_start, load_alu, load_done;

    // Handshake: a transfer happens on a rising edge where valid && ready; a
    // holder of valid keeps its bundle unchanged until that edge. flush wins.
    assign out_free  = !out_valid || out_ready;
    assign in_ready  = (mdu_state == IDLE) && out_free;
    assign accept    = in_valid && in_ready && !flush;
    assign mdu_start = accept && (mdu_op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU});
    assign load_alu  = accept && !mdu_start;
    assign load_done = (mdu_state == DONE) && out_free && !flush;

    assign op_b = alu_src ? imm_ext : rt_data;
    assign op5  = 5'(alu_op);
    assign zero = (alu_result == '0);

    always_comb begin
        alu_y = '0;
        case (op5)
            ALU_ADD:  alu_y = rs_data + op_b;
            ALU_SUB:  alu_y = rs_data - op_b;
            ALU_AND:  alu_y = rs_data & op_b;
            ALU_OR:   alu_y = rs_data | op_b;
            ALU_XOR:  alu_y = rs_data ^ op_b;
            ALU_NOR:  alu_y = ~(rs_data | op_b);
            ALU_SLT:  alu_y = {{(XLEN-1){1'b0}}, $signed(rs_data) < $signed(op_b)};
            ALU_SLTU: alu_y = {{(XLEN-1){1'b0}}, rs_data < op_b};
            ALU_SLL:  alu_y = op_b << shamt;
            ALU_SRL:  alu_y = op_b >> shamt;
            ALU_SRA:  alu_y = $signed(op_b) >>> shamt;
            ALU_LUI:  alu_y = op_b << (XLEN / 2);
            default:  alu_y = '0;
        endcase
    end

    always_comb begin
        case (mdu_op)
            MDU_MFHI: ex_y = hi;
            MDU_MFLO: ex_y = lo;
            default:  ex_y = alu_y;
        endcase
    end

    always_comb begin
        case (dest_sel)
            DEST_RT: dest = inst_rt;
            DEST_RD: dest = inst_rd;
            DEST_RA: dest = '1;
            default: dest = inst_rt;
        endcase
    end

    ex_mdu #(
        .XLEN     (XLEN),
        .MUL_STEP (MUL_STEP)
    ) u_mdu (
        .clk      (clk),
        .rst_b    (rst_b),
        .start    (mdu_start),
        .op       (mdu_op),
        .a        (rs_data),
        .b        (op_b),
        .abort    (flush),
        .done_ack (out_free),
        .state    (mdu_state),
        .busy     (mdu_busy),
        .hi       (hi),
        .lo       (lo)
    );

    // MDU ops park their sideband here until DONE emits the bundle.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            out_valid  <= 1'b0;
            alu_result <= '0;
            rt_out     <= '0;
            rd_num     <= '0;
            ctrl_out   <= '0;
            cap_rt     <= '0;
            cap_rd     <= '0;
            cap_ctrl   <= '0;
        end else begin
            if (mdu_start) begin
                cap_rt   <= rt_data;
                cap_rd   <= dest;
                cap_ctrl <= ctrl_in;
            end
            if (flush) begin
                out_valid <= 1'b0;
            end else if (load_alu) begin
                out_valid  <= 1'b1;
                alu_result <= ex_y;
                rt_out     <= rt_data;
                rd_num     <= dest;
                ctrl_out   <= ctrl_in;
            end else if (load_done) begin
                out_valid  <= 1'b1;
                alu_result <= '0;
                rt_out     <= cap_rt;
                rd_num     <= cap_rd;
                ctrl_out   <= cap_ctrl;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Bench for ex_stage_pipe: directed scenarios plus random traffic checked
// against an arithmetic reference model of the ALU, MDU and HI/LO.
module tb_ex_stage_pipe;
    import ex_pkg::*;

    localparam int XLEN    = 32;
    localparam int MUL_CYC = 33;
    localparam int DIV_CYC = 33;

    logic        clk = 1'b0;
    logic        rst_b = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] rs_data = '0, rt_data = '0, imm_ext = '0;
    logic [4:0]  shamt = '0, inst_rt = '0, inst_rd = '0;
    logic [1:0]  dest_sel = '0;
    logic        alu_src = 1'b0;
    logic [4:0]  alu_op = '0;
    logic [2:0]  mdu_op = '0;
    logic [15:0] ctrl_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] alu_result, rt_out;
    logic        zero, mdu_busy;
    logic [4:0]  rd_num;
    logic [15:0] ctrl_out;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] hi_m = '0, lo_m = '0;
    logic [52:0] exp_q[$];

    always #5 clk = ~clk;

    ex_stage_pipe dut (
        .clk(clk), .rst_b(rst_b), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .rs_data(rs_data), .rt_data(rt_data), .imm_ext(imm_ext), .shamt(shamt),
        .inst_rt(inst_rt), .inst_rd(inst_rd), .dest_sel(dest_sel), .alu_src(alu_src),
        .alu_op(alu_op), .mdu_op(mdu_op), .ctrl_in(ctrl_in), .out_valid(out_valid),
        .out_ready(out_ready), .alu_result(alu_result), .zero(zero), .rt_out(rt_out),
        .rd_num(rd_num), .ctrl_out(ctrl_out), .mdu_busy(mdu_busy)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_NOR:  return ~(a | b);
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_SLL:  return b << sh;
            ALU_SRL:  return b >> sh;
            ALU_SRA:  return 32'($signed(b) >>> sh);
            ALU_LUI:  return {b[15:0], 16'h0000};
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic [4:0] dest_ref(input logic [1:0] dsel, input logic [4:0] rt,
                                            input logic [4:0] rd);
        if (dsel == 2'b01) return rd;
        if (dsel == 2'b10) return 5'h1F;
        return rt;
    endfunction

    task automatic mdu_ref(input logic [2:0] mop, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, q, r;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        case (mop)
            3'd1: begin p = sa * sb; hi_m = p[63:32]; lo_m = p[31:0]; end
            3'd2: begin up = ua * ub; hi_m = up[63:32]; lo_m = up[31:0]; end
            3'd3: begin
                if (b == 0) begin lo_m = '1; hi_m = a; end
                else begin q = sa / sb; r = sa % sb; lo_m = q[31:0]; hi_m = r[31:0]; end
            end
            default: begin
                if (b == 0) begin lo_m = '1; hi_m = a; end
                else begin lo_m = a / b; hi_m = a % b; end
            end
        endcase
    endtask

    task automatic drive(input logic [4:0] aop, input logic [2:0] mop, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic src,
                         input logic [4:0] sh, input logic [1:0] dsel, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] ctrl);
        alu_op = aop; mdu_op = mop; rs_data = a; rt_data = b; imm_ext = imm;
        alu_src = src; shamt = sh; dest_sel = dsel; inst_rt = rt; inst_rd = rd; ctrl_in = ctrl;
    endtask

    // Raise in_valid, wait (bounded) for in_ready, hand over on the next edge.
    task automatic fire(input string tag);
        int t;
        t = 0;
        in_valid = 1'b1;
        #1;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check({tag, " accept timeout"}, in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_busy(output int cyc);
        cyc = 0;
        @(negedge clk);
        while (mdu_busy && cyc < 300) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic [4:0] aop, input logic [2:0] mop,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                          input logic src, input logic [4:0] sh, input logic [1:0] dsel,
                          input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] ctrl);
        logic [31:0] opb, res;
        logic [52:0] e;
        logic        is_mdu;
        int          cyc;
        opb    = src ? imm : b;
        is_mdu = (mop >= 3'd1) && (mop <= 3'd4);
        if (is_mdu) begin
            res = '0;
            mdu_ref(mop, a, opb);
        end else if (mop == 3'd5) res = hi_m;
        else if (mop == 3'd6) res = lo_m;
        else res = alu_ref(aop, a, opb, sh);
        exp_q.push_back({res, dest_ref(dsel, rt, rd), ctrl});
        @(negedge clk);
        drive(aop, mop, a, b, imm, src, sh, dsel, rt, rd, ctrl);
        fire(tag);
        if (is_mdu) begin
            wait_busy(cyc);
            check({tag, " busy cycles"}, cyc, (mop <= 3'd2) ? MUL_CYC : DIV_CYC);
        end else begin
            @(negedge clk);
        end
        e = exp_q.pop_front();
        check({tag, " out_valid"}, out_valid, 1);
        check({tag, " alu_result"}, alu_result, e[52:21]);
        check({tag, " zero"}, zero, (e[52:21] == 0));
        check({tag, " rd_num"}, rd_num, e[20:16]);
        check({tag, " ctrl_out"}, ctrl_out, e[15:0]);
        if (!is_mdu) check({tag, " rt_out"}, rt_out, b);
    endtask

    initial begin
        logic [4:0]  aop, sh, rt, rd;
        logic [2:0]  mop;
        logic [31:0] a, b, imm;
        logic [1:0]  dsel;
        logic        src;
        int          kind;

        // Reset state
        #2 rst_b = 1'b0;
        #1;
        check("rst out_valid", out_valid, 0);
        check("rst mdu_busy", mdu_busy, 0);
        check("rst in_ready", in_ready, 1);
        check("rst alu_result", alu_result, 0);
        check("rst zero", zero, 1);
        check("rst rd_num", rd_num, 0);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;

        // ADD with rd destination, zero result, RA destination
        run_op("add", ALU_ADD, MDU_NONE, 32'd5, 32'd7, 32'd0, 1'b0, 5'd0, 2'b01, 5'd3, 5'd9, 16'hA5A5);
        run_op("sub zero", ALU_SUB, MDU_NONE, 32'd9, 32'd9, 32'd0, 1'b0, 5'd0, 2'b00, 5'd4, 5'd8, 16'h0001);
        run_op("dest ra", ALU_OR, MDU_NONE, 32'hF0, 32'd0, 32'h0F, 1'b1, 5'd0, 2'b10, 5'd1, 5'd2, 16'h1234);
        run_op("sra", ALU_SRA, MDU_NONE, 32'd0, 32'h8000_0010, 32'd0, 1'b0, 5'd4, 2'b11, 5'd6, 5'd7, 16'h0);

        // Backpressure: output holds, in_ready low, then resumes
        @(negedge clk);
        out_ready = 1'b0;
        drive(ALU_ADD, MDU_NONE, 32'd10, 32'd20, 32'd0, 1'b0, 5'd0, 2'b01, 5'd0, 5'd11, 16'hBEEF);
        in_valid = 1'b1;
        #1 check("bp first ready", in_ready, 1);
        @(posedge clk);
        #1 drive(ALU_SUB, MDU_NONE, 32'd50, 32'd8, 32'd0, 1'b0, 5'd0, 2'b01, 5'd0, 5'd12, 16'hCAFE);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp valid", out_valid, 1);
            check("bp result", alu_result, 32'd30);
            check("bp rd", rd_num, 5'd11);
            check("bp in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1 check("bp release ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("bp second result", alu_result, 32'd42);
        check("bp second rd", rd_num, 5'd12);
        check("bp second ctrl", ctrl_out, 16'hCAFE);

        // MULT / DIV / DIVU by zero with HI/LO readback
        run_op("mult", ALU_ADD, MDU_MULT, 32'hFFFF_FFFD, 32'd4, 32'd0, 1'b0, 5'd0, 2'b01, 5'd0, 5'd13, 16'h0042);
        run_op("mflo", ALU_ADD, MDU_MFLO, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 2'b01, 5'd0, 5'd14, 16'h0);
        run_op("mfhi", ALU_ADD, MDU_MFHI, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 2'b01, 5'd0, 5'd15, 16'h0);
        check("model mult lo", lo_m, 32'hFFFF_FFF4);
        run_op("div", ALU_ADD, MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0, 5'd0, 2'b00, 5'd16, 5'd0, 16'h0007);
        run_op("div mflo", ALU_ADD, MDU_MFLO, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 2'b00, 5'd1, 5'd0, 16'h0);
        run_op("div mfhi", ALU_ADD, MDU_MFHI, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 2'b00, 5'd1, 5'd0, 16'h0);
        run_op("divu0", ALU_ADD, MDU_DIVU, 32'd7, 32'd0, 32'd0, 1'b0, 5'd0, 2'b00, 5'd2, 5'd0, 16'h0);
        run_op("divu0 mflo", ALU_ADD, MDU_MFLO, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 2'b00, 5'd1, 5'd0, 16'h0);
        run_op("divu0 mfhi", ALU_ADD, MDU_MFHI, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 2'b00, 5'd1, 5'd0, 16'h0);

        // Flush mid-multiply: HI/LO keep 1/2
        run_op("multu 1:2", ALU_ADD, MDU_MULTU, 32'd2, 32'h8000_0001, 32'd0, 1'b0, 5'd0, 2'b00, 5'd3, 5'd0, 16'h0);
        @(negedge clk);
        drive(ALU_ADD, MDU_MULT, 32'd123, 32'd456, 32'd0, 1'b0, 5'd0, 2'b00, 5'd5, 5'd0, 16'h0);
        fire("flush mult");
        repeat (10) @(negedge clk);
        check("flush busy before", mdu_busy, 1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush busy after", mdu_busy, 0);
        check("flush out_valid", out_valid, 0);
        check("flush in_ready", in_ready, 1);
        run_op("flush mfhi", ALU_ADD, MDU_MFHI, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 2'b00, 5'd1, 5'd0, 16'h0);
        run_op("flush mflo", ALU_ADD, MDU_MFLO, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 2'b00, 5'd1, 5'd0, 16'h0);

        // Same-cycle in_valid dropped by flush
        @(negedge clk);
        drive(ALU_ADD, MDU_NONE, 32'd1, 32'd1, 32'd0, 1'b0, 5'd0, 2'b00, 5'd1, 5'd0, 16'h0);
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1 begin in_valid = 1'b0; flush = 1'b0; end
        @(negedge clk);
        check("flush drop valid", out_valid, 0);

        // Asynchronous reset mid-divide
        @(negedge clk);
        drive(ALU_ADD, MDU_DIV, 32'd1000, 32'd7, 32'd0, 1'b0, 5'd0, 2'b01, 5'd0, 5'd21, 16'h5555);
        fire("rst div");
        repeat (5) @(negedge clk);
        rst_b = 1'b0;
        #1;
        hi_m = '0;
        lo_m = '0;
        check("mid rst busy", mdu_busy, 0);
        check("mid rst out_valid", out_valid, 0);
        check("mid rst alu_result", alu_result, 0);
        check("mid rst rd_num", rd_num, 0);
        check("mid rst ctrl_out", ctrl_out, 0);
        check("mid rst rt_out", rt_out, 0);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        check("post rst in_ready", in_ready, 1);
        run_op("post rst mfhi", ALU_ADD, MDU_MFHI, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 2'b00, 5'd1, 5'd0, 16'h0);

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            a    = $urandom;
            b    = $urandom;
            imm  = $urandom;
            sh   = 5'($urandom_range(0, 31));
            dsel = 2'($urandom_range(0, 3));
            rt   = 5'($urandom_range(0, 31));
            rd   = 5'($urandom_range(0, 31));
            aop  = 5'($urandom_range(0, 11));
            src  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 20);
            mop = MDU_NONE;
            if (kind == 6 || kind == 7) begin
                mop = 3'($urandom_range(1, 4));
                src = 1'b0;
                if (mop >= 3'd3 && $urandom_range(0, 5) == 0) b = '0;
            end else if (kind == 8) mop = MDU_MFHI;
            else if (kind == 9) mop = MDU_MFLO;
            run_op($sformatf("rnd%0d", i), aop, mop, a, b, imm, src, sh, dsel, rt, rd,
                   16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
